// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for mul_exec; MUL_RADIX4_EN selects bits retired per CALC cycle
package mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

`ifdef MUL_RADIX4_EN
    localparam int STEP_BITS = 2;
`else
    localparam int STEP_BITS = 1;
`endif

    localparam int N_ITER = XLEN / STEP_BITS;

    // Two's-complement magnitude; -2^31 maps to 2^31, which still fits unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_iter_step.sv
// rtl/mul_iter_step.sv - one shift-add step; retires STEP_BITS multiplier bits (2 when MUL_RADIX4_EN is defined)
module mul_iter_step
    import mul_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [XLEN-1:0]   mplier,
    output logic [2*XLEN-1:0] acc_next,
    output logic [2*XLEN-1:0] mcand_next,
    output logic [XLEN-1:0]   mplier_next
);

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (mplier[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
        mcand_next  = mcand << STEP_BITS;
        mplier_next = mplier >> STEP_BITS;
    end

endmodule

// File: rtl/mul_exec.sv
// rtl/mul_exec.sv - iterative RV32M multiply unit (MUL/MULH/MULHSU/MULHU); MUL_RADIX4_EN halves the iteration count
module mul_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      ex_type_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_wb,
    output logic [XLEN:0]   mul_data
);
    import mul_pkg::*;

    localparam logic [5:0] LAST_ITER = 6'(N_ITER - 1);

    mul_state_t        state;
    mul_op_t           op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]   mplier;

    logic [2*XLEN-1:0] acc_next, mcand_next, prod_fin;
    logic [XLEN-1:0]   mplier_next, result;
    logic              neg1, neg2;
    logic              unused_type_bits;

    assign unused_type_bits = ^ex_type_in[5:2];

    assign neg1 = operand1[XLEN-1] && (ex_type_in[1:0] == OP_MULH || ex_type_in[1:0] == OP_MULHSU);
    assign neg2 = operand2[XLEN-1] && (ex_type_in[1:0] == OP_MULH);

    mul_iter_step u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    // Sign fix-up and selection use the final accumulate so the result registers on entry to DONE.
    assign prod_fin = neg_q ? (~acc_next + 1'b1) : acc_next;
    assign result   = (op_q == OP_MUL) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            done     <= 1'b0;
            rd_wb    <= '0;
            mul_data <= '0;
        end else begin
            done  <= 1'b0;
            rd_wb <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= CALC;
                        op_q           <= mul_op_t'(ex_type_in[1:0]);
                        rd_q           <= rd_in;
                        neg_q          <= neg1 ^ neg2;
                        mcand          <= {{XLEN{1'b0}}, magnitude(operand1, neg1)};
                        mplier         <= magnitude(operand2, neg2);
                        acc            <= '0;
                        cnt            <= '0;
                        mul_data[XLEN] <= 1'b0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        rd_wb    <= rd_q;
                        mul_data <= {1'b1, result};
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_exec.sv
// tb/tb_mul_exec.sv - scoreboard bench for mul_exec with directed corners and random ops
module tb_mul_exec;

`ifdef MUL_RADIX4_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  ex_type_in;
    logic [4:0]  rd_in;
    logic [31:0] operand1, operand2;
    logic        busy, done;
    logic [4:0]  rd_wb;
    logic [32:0] mul_data;

    mul_exec #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ex_type_in (ex_type_in),
        .rd_in      (rd_in),
        .operand1   (operand1),
        .operand2   (operand2),
        .busy       (busy),
        .done       (done),
        .rd_wb      (rd_wb),
        .mul_data   (mul_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_hold = '0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: exact product of sign/zero-extended operands, 64-bit wrap keeps the needed bits.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      x, y;
        logic [63:0] p;
        x = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        y = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        p = 64'(x * y);
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (prev_done) check("done_single_cycle", 64'(done), 64'(0));
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("mul_data", 64'(mul_data), 64'({1'b1, e.res}));
                    check("rd_wb", 64'(rd_wb), 64'(e.rd));
                    check("latency", 64'(cyc), 64'(e.acc_cyc + N));
                    exp_hold = {1'b1, e.res};
                end
            end else begin
                check("rd_wb_idle", 64'(rd_wb), 64'(0));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expv, input bit spur);
        int w = 0;
        @(negedge clk);
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got busy=1 expected idle within 200 cycles");
            return;
        end
        check("hold_valid", 64'(mul_data), 64'(exp_hold));
        start      = 1'b1;
        ex_type_in = {4'($urandom), op};
        rd_in      = rd;
        operand1   = a;
        operand2   = b;
        exp_q.push_back('{expv, rd, cyc + 1});
        @(negedge clk);
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        rd_in    = 5'($urandom);
        check("busy_on_accept", 64'(busy), 64'(1));
        check("valid_drop", 64'(mul_data[32]), 64'(0));
        if (spur) begin
            repeat (4) @(negedge clk);
            start      = 1'b1;
            ex_type_in = 6'($urandom);
            operand1   = $urandom;
            operand2   = $urandom;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          w;
        rst_n      = 1'b0;
        start      = 1'b0;
        ex_type_in = '0;
        rd_in      = '0;
        operand1   = '0;
        operand2   = '0;
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_mul_data", 64'(mul_data), 64'(0));
        check("reset_rd_wb", 64'(rd_wb), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(2'b00, 32'd7, 32'd6, 5'd9, 32'h0000_002A, 1'b0);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b0);
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2, 32'hFFFF_FFFF, 1'b0);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b0);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 1'b0);
        issue(2'b00, 32'd100, 32'd200, 5'd6, 32'd20000, 1'b1);
        issue(2'b00, 32'd0, 32'hFFFF_FFFF, 5'd7, 32'd0, 1'b0);

        // Mid-CALC asynchronous reset discards the op in flight.
        issue(2'b00, 32'h1234, 32'h5678, 5'd8, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        check("midreset_mul_data", 64'(mul_data), 64'(0));
        check("midreset_rd_wb", 64'(rd_wb), 64'(0));
        exp_q.delete();
        exp_hold = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'b00, 32'd3, 32'd5, 5'd10, 32'h0000_000F, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            issue(op, a, b, 5'($urandom), ref_mul(op, a, b), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_exec.md
MUL_EXEC -- requirements
Module: mul_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have clk, input, 1, clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have start, input, 1: request to accept a new multiply, from the issue station.
REQ-005 SHALL have ex_type_in, input, 6: operation code; bits [1:0] are 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have rd_in, input, 5: destination register of the operation.
REQ-007 SHALL have operand1 and operand2, input, 32 each: rs1 and rs2 values.
REQ-008 SHALL have busy, output, 1: high whenever the unit is not IDLE.
REQ-009 SHALL have done, output, 1: single-cycle writeback strobe.
REQ-010 SHALL have rd_wb, output, 5: equals the latched rd while done is high, else 0.
REQ-011 SHALL have mul_data, output, 33: bit 32 is valid and [31:0] is the result; this is the same forwarding format the issue stations consume.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
  - IDLE to CALC on start.
  - CALC to DONE after N iterations.
  - DONE to IDLE unconditionally.
REQ-013 SHALL accept start only in IDLE; start in CALC or DONE is ignored with no effect on state or data.
REQ-014 SHALL, on an accepted start:
  - latch rd_in, ex_type_in[1:0], and the operand magnitudes and signs;
  - clear mul_data[32];
  - clear the 64-bit accumulator and the iteration counter.
REQ-015 SHALL treat operand signs as follows:
  - operand1 is signed for MULH and MULHSU;
  - operand2 is signed for MULH only;
  - a signed negative operand is replaced by its two's-complement magnitude.
REQ-016 SHALL run a shift-add iteration over the unsigned magnitudes, 1 multiplier bit per CALC cycle (N=32) by default.
REQ-017 SHALL negate the 64-bit product in DONE when exactly one signed operand was negative.
REQ-018 SHALL select the result: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
REQ-019 SHALL assert done for exactly one cycle, in DONE.
  - Latency from the start-accept edge T to the done cycle is N+1 cycles (done high in cycle T+N+1).
REQ-020 SHALL set mul_data = {1'b1, result} from the DONE cycle onward.
  - The value holds until the next accepted start or reset, so a waiting issue station can sample it late.
REQ-021 SHALL give exact results for zero operands, -2^31 operands, and all-ones operands with no overflow flagging.
REQ-022 SHALL allow start in the cycle after DONE (back-to-back throughput of one op per N+2 cycles).

Reset
REQ-023 SHALL, while rst_n is low, force the following regardless of clk, including mid-CALC:
  - state = IDLE, busy = 0, done = 0, rd_wb = 0;
  - mul_data = 33'd0, accumulator = 0, counter = 0.
REQ-024 SHALL begin normal operation on the first rising clk edge after rst_n deasserts; no operation resumes.

Configuration
REQ-025 SHALL, when macro MUL_RADIX4_EN is defined, retire 2 multiplier bits per CALC cycle (N=16, done at T+17).
REQ-026 SHALL, when MUL_RADIX4_EN is undefined, use radix-2 (N=32, done at T+33).
REQ-027 SHALL produce bit-identical results in both configurations.

Structure
REQ-028 SHALL place the following in shared package mul_pkg:
  - state encodings (IDLE=2'b00, CALC=2'b01, DONE=2'b10);
  - MUL/MULH/MULHSU/MULHU codes;
  - the XLEN constant.
REQ-029 SHALL isolate the per-cycle partial-product/accumulate datapath in sub-module mul_iter_step.
  - Its width is selected by MUL_RADIX4_EN.
  - Control and sign handling remain in mul_exec.

Verification
REQ-030 SHALL cover: MUL 7 x 6 -> mul_data = 33'h1_0000002A; done one cycle at T+33 (T+17 radix-4); rd_wb = rd_in only in that cycle.
REQ-031 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-032 SHALL cover: MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same pair -> 0x00000001.
REQ-033 SHALL cover: start pulsed at T+5 during CALC with different operands -> ignored; the first result is unchanged and done is still at T+33.
REQ-034 SHALL cover: rst_n low at T+10 mid-CALC -> busy=0, mul_data=0, done never asserts; a fresh MUL 3 x 5 afterwards -> 0x0000000F.
REQ-035 SHALL cover: back-to-back ops with start in the cycle after done -> accepted; mul_data[32] drops on accept and rises on the second done.
